// File: rtl/serial_uart_pkg.sv
// Shared types and helpers for the parametrised FIFO-buffered UART.
// State encodings, parity modes and the parity bit function.
package serial_uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Zero-padded data; padding does not change the XOR.
   function automatic logic parity_bit(input logic [8:0] d,
                                       input int mode);
      return (mode == PARITY_ODD) ? ~(^d) : ^d;
   endfunction

endpackage

// File: rtl/serial_fifo.sv
// Synchronous first-word fall-through FIFO.
// dout holds the last popped word while the FIFO is empty.
module serial_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] last;
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? last : mem[rptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         last  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop) begin
            rptr <= rptr + 1'b1;
            last <= mem[rptr];
         end
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/serial_fifo_uart.sv
// Full-duplex UART with TX/RX FIFOs, optional parity
// and sticky framing/parity/overrun flags.
module serial_fifo_uart
   import serial_uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int CLK_DIV     = 434,
   parameter int FIFO_DEPTH  = 16,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serDataIn,
   output logic                 serDataOut,
   input  logic [DATA_BITS-1:0] txData,
   input  logic                 txLoad,
   output logic                 txFull,
   output logic                 txIdle,
   output logic [DATA_BITS-1:0] rxData,
   input  logic                 rxRead,
   output logic                 rxEmpty,
   output logic                 charReceived,
   output logic                 frameErr,
   output logic                 parityErr,
   output logic                 overrun,
   input  logic                 errClear
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = $clog2(DATA_BITS+1);
   localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV-1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV/2-1);
   localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS-1);
   localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS-1);

   tx_state_t            tx_st, tx_nx;
   logic [CW-1:0]        tx_cnt, tx_cnt_n;
   logic [IW-1:0]        tx_idx, tx_idx_n;
   logic [DATA_BITS-1:0] tx_sh, tx_sh_n, tx_head;
   logic                 tx_par, tx_par_n;
   logic                 tx_line, tx_line_n;
   logic                 tx_pop, tx_empty, tx_end;

   rx_state_t            rx_st, rx_nx;
   logic [CW-1:0]        rx_cnt, rx_cnt_n;
   logic [IW-1:0]        rx_idx, rx_idx_n;
   logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
   logic                 rx_s1, rx_s2;
   logic                 rx_bad, rx_bad_n;
   logic                 rx_wait, rx_wait_n;
   logic                 rx_push, rx_push_n;
   logic                 rx_full, rx_end, rx_half;
   logic                 frame_set, par_set, ovr_set;

   serial_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
      .clk   (clk),
      .reset (reset),
      .push  (txLoad),
      .pop   (tx_pop),
      .din   (txData),
      .dout  (tx_head),
      .full  (txFull),
      .empty (tx_empty)
   );

   serial_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rxf (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .pop   (rxRead),
      .din   (rx_sh),
      .dout  (rxData),
      .full  (rx_full),
      .empty (rxEmpty)
   );

   assign serDataOut   = tx_line;
   assign txIdle       = (tx_st == TX_IDLE) & tx_empty;
   assign charReceived = rx_push;
   assign tx_end       = (tx_cnt == DIV_LAST);
   assign rx_end       = (rx_cnt == DIV_LAST);
   assign rx_half      = (rx_cnt == HALF_LAST);

   always_comb begin
      tx_nx    = tx_st;
      tx_idx_n = tx_idx;
      tx_sh_n  = tx_sh;
      tx_par_n = tx_par;
      tx_pop   = 1'b0;
      tx_cnt_n = (tx_st == TX_IDLE || tx_end) ? '0 : tx_cnt + 1'b1;
      unique case (tx_st)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_pop = 1'b1;
               tx_nx  = TX_START;
            end
         end
         TX_START: begin
            if (tx_end) begin
               tx_nx    = TX_DATA;
               tx_idx_n = '0;
            end
         end
         TX_DATA: begin
            if (tx_end) begin
               tx_sh_n = tx_sh >> 1;
               if (tx_idx == DATA_LAST) begin
                  tx_idx_n = '0;
                  tx_nx = (PARITY_MODE == PARITY_NONE) ? TX_STOP : TX_PARITY;
               end else begin
                  tx_idx_n = tx_idx + 1'b1;
               end
            end
         end
         TX_PARITY: begin
            if (tx_end) tx_nx = TX_STOP;
         end
         TX_STOP: begin
            if (tx_end) begin
               if (tx_idx == STOP_LAST) begin
                  tx_idx_n = '0;
                  // back-to-back frames skip the idle state
                  if (!tx_empty) begin
                     tx_pop = 1'b1;
                     tx_nx  = TX_START;
                  end else begin
                     tx_nx  = TX_IDLE;
                  end
               end else begin
                  tx_idx_n = tx_idx + 1'b1;
               end
            end
         end
         default: tx_nx = TX_IDLE;
      endcase
      if (tx_pop) begin
         tx_sh_n  = tx_head;
         tx_par_n = parity_bit(9'(tx_head), PARITY_MODE);
      end
      unique case (tx_nx)
         TX_START:  tx_line_n = 1'b0;
         TX_DATA:   tx_line_n = tx_sh_n[0];
         TX_PARITY: tx_line_n = tx_par_n;
         default:   tx_line_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_st   <= TX_IDLE;
         tx_cnt  <= '0;
         tx_idx  <= '0;
         tx_sh   <= '0;
         tx_par  <= 1'b0;
         tx_line <= 1'b1;
      end else begin
         tx_st   <= tx_nx;
         tx_cnt  <= tx_cnt_n;
         tx_idx  <= tx_idx_n;
         tx_sh   <= tx_sh_n;
         tx_par  <= tx_par_n;
         tx_line <= tx_line_n;
      end
   end

   always_comb begin
      rx_nx     = rx_st;
      rx_cnt_n  = rx_cnt + 1'b1;
      rx_idx_n  = rx_idx;
      rx_sh_n   = rx_sh;
      rx_bad_n  = rx_bad;
      rx_wait_n = rx_wait;
      rx_push_n = 1'b0;
      frame_set = 1'b0;
      par_set   = 1'b0;
      ovr_set   = 1'b0;
      unique case (rx_st)
         RX_IDLE: begin
            rx_cnt_n = '0;
            rx_bad_n = 1'b0;
            if (!rx_s2) rx_nx = RX_START;
         end
         RX_START: begin
            if (rx_half) begin
               rx_cnt_n = '0;
               rx_idx_n = '0;
               rx_nx    = rx_s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_end) begin
               rx_cnt_n = '0;
               rx_sh_n  = {rx_s2, rx_sh[DATA_BITS-1:1]};
               if (rx_idx == DATA_LAST) begin
                  rx_idx_n = '0;
                  rx_nx = (PARITY_MODE == PARITY_NONE) ? RX_STOP : RX_PARITY;
               end else begin
                  rx_idx_n = rx_idx + 1'b1;
               end
            end
         end
         RX_PARITY: begin
            if (rx_end) begin
               rx_cnt_n = '0;
               rx_bad_n = rx_s2 ^ parity_bit(9'(rx_sh), PARITY_MODE);
               rx_nx    = RX_STOP;
            end
         end
         RX_STOP: begin
            // after a framing error, hold off until the line idles
            if (rx_wait) begin
               rx_cnt_n = '0;
               if (rx_s2) begin
                  rx_wait_n = 1'b0;
                  rx_nx     = RX_IDLE;
               end
            end else if (rx_end) begin
               rx_cnt_n = '0;
               if (!rx_s2) begin
                  frame_set = 1'b1;
                  rx_wait_n = 1'b1;
               end else begin
                  rx_nx = RX_IDLE;
                  if (rx_bad)       par_set   = 1'b1;
                  else if (rx_full) ovr_set   = 1'b1;
                  else              rx_push_n = 1'b1;
               end
            end
         end
         default: rx_nx = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_st     <= RX_IDLE;
         rx_cnt    <= '0;
         rx_idx    <= '0;
         rx_sh     <= '0;
         rx_bad    <= 1'b0;
         rx_wait   <= 1'b0;
         rx_push   <= 1'b0;
         frameErr  <= 1'b0;
         parityErr <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         rx_s1   <= serDataIn;
         rx_s2   <= rx_s1;
         rx_st   <= rx_nx;
         rx_cnt  <= rx_cnt_n;
         rx_idx  <= rx_idx_n;
         rx_sh   <= rx_sh_n;
         rx_bad  <= rx_bad_n;
         rx_wait <= rx_wait_n;
         rx_push <= rx_push_n;
         if (errClear) begin
            frameErr  <= 1'b0;
            parityErr <= 1'b0;
            overrun   <= 1'b0;
         end else begin
            if (frame_set) frameErr  <= 1'b1;
            if (par_set)   parityErr <= 1'b1;
            if (ovr_set)   overrun   <= 1'b1;
         end
      end
   end

endmodule
